// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: state encoding, funct3 constants and access-size decode
// shared by dmem_access_ctrl and lsu_lane_align.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    // Any funct3 that is not a byte or half encoding is handled as a word access.
    function automatic size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for stores, lane select and
// sign/zero extension for loads, and misalignment detection.
// The request side decodes the live EX/MEM operation; the response side
// decodes the latched operation while the memory word returns.
module lsu_lane_align
    import dmem_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_req_addr_lo,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_wdata,
    input  logic [1:0]      i_rsp_addr_lo,
    input  logic [2:0]      i_rsp_funct3,
    input  logic [XLEN-1:0] i_rsp_word,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_ld_data,
    output logic            o_misaligned
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic        w_sext;

    assign w_ld_byte = i_rsp_word[{i_rsp_addr_lo, 3'b000} +: 8];
    assign w_ld_half = i_rsp_addr_lo[1] ? i_rsp_word[31:16] : i_rsp_word[15:0];
    assign w_sext    = ~i_rsp_funct3[2];

    // Store side: byte enables, replicated write data and misalignment flag.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_be         = 4'b1111;
        o_wdata      = i_req_wdata;
        o_misaligned = |i_req_addr_lo;
        case (f3_size(i_req_funct3))
            SZ_BYTE: begin
                o_be         = 4'b0001 << i_req_addr_lo;
                o_wdata      = {(XLEN/8){i_req_wdata[7:0]}};
                o_misaligned = 1'b0;
            end
            SZ_HALF: begin
                o_be         = 4'b0011 << {i_req_addr_lo[1], 1'b0};
                o_wdata      = {(XLEN/16){i_req_wdata[15:0]}};
                o_misaligned = i_req_addr_lo[0];
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane and extend it to XLEN.
    always_comb begin
        o_ld_data = i_rsp_word;
        case (f3_size(i_rsp_funct3))
            SZ_BYTE: o_ld_data = {{(XLEN-8){w_sext & w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: o_ld_data = {{(XLEN-16){w_sext & w_ld_half[15]}}, w_ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage sequencer for the data-memory req/ack port.
// Latches the EX/MEM operation, issues one request, stalls the pipeline until
// ack, and presents the extended load result with a one-cycle mem_done.
// Optional build macro DMEM_TIMEOUT_EN bounds the REQ state to TMO_CYCLES.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TMO_CYCLES = 255,
    parameter int TMO_W      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MemRead_MEM,
    input  logic            MemWrite_MEM,
    input  logic [2:0]      funct3_MEM,
    input  logic [XLEN-1:0] alu_MEM,
    input  logic [XLEN-1:0] rs2_mem_data_MEM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] mem_rdata_MEM,
    output logic            mem_stall,
    output logic            mem_done,
    output logic            mem_err
);

    // The timeout counter must be able to hold TMO_CYCLES.
    if ((2 ** TMO_W) <= TMO_CYCLES) begin : g_bad_tmo_w
        $error("TMO_W too small for TMO_CYCLES");
    end

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
    logic [3:0]      r_be;
    logic            r_we, r_err;
    logic [1:0]      r_addr_lo;
    logic [2:0]      r_funct3;

    logic            w_op, w_misaligned, w_tmo_hit;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata, w_ld_data;

    // A simultaneous read and write is treated as a read.
    assign w_op = MemRead_MEM | MemWrite_MEM;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .i_req_addr_lo (alu_MEM[1:0]),
        .i_req_funct3  (funct3_MEM),
        .i_req_wdata   (rs2_mem_data_MEM),
        .i_rsp_addr_lo (r_addr_lo),
        .i_rsp_funct3  (r_funct3),
        .i_rsp_word    (dmem_rdata),
        .o_be          (w_be),
        .o_wdata       (w_wdata),
        .o_ld_data     (w_ld_data),
        .o_misaligned  (w_misaligned)
    );

`ifdef DMEM_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TMO_CYCLES - 1));

    // Counts REQ cycles without ack; cleared while idle so each access starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state != REQ) begin
            r_tmo_cnt <= '0;
        end else if (!dmem_ack) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    // State register; reset forces IDLE at once, which also drops dmem_req.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and the state-decoded handshake/stall outputs.
    always_comb begin
        w_state_nxt = r_state;
        dmem_req    = 1'b0;
        mem_stall   = 1'b0;
        mem_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_op) begin
                    mem_stall   = 1'b1;
                    w_state_nxt = w_misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                dmem_req  = 1'b1;
                mem_stall = 1'b1;
                if (dmem_ack || w_tmo_hit) w_state_nxt = DONE;
            end
            DONE: begin
                mem_done    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latch at op acceptance; result and error capture at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_we      <= 1'b0;
            r_addr_lo <= '0;
            r_funct3  <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_op) begin
                        r_addr    <= {alu_MEM[XLEN-1:2], 2'b00};
                        r_wdata   <= w_wdata;
                        r_be      <= w_be;
                        r_we      <= MemWrite_MEM & ~MemRead_MEM;
                        r_addr_lo <= alu_MEM[1:0];
                        r_funct3  <= funct3_MEM;
                        r_err     <= w_misaligned;
                        if (w_misaligned) r_rdata <= '0;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        r_err   <= 1'b0;
                        r_rdata <= r_we ? '0 : w_ld_data;
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_we       = r_we;
    assign dmem_addr     = r_addr;
    assign dmem_wdata    = r_wdata;
    assign dmem_be       = r_be;
    assign mem_rdata_MEM = r_rdata;
    assign mem_err       = r_err;

endmodule
